data_memory_line: RTL and testbench

Line-granular backing store for the data cache: accepts one 256-bit line read or write request at a time and completes it after a fixed latency, signalled by a single-cycle `ack_o` pulse. It sits directly downstream of the data cache's memory port. Write-backs and refills arrive as separate back-to-back requests, and the block must accept a new request on the cycle after each acknowledge.

---
 rtl/data_memory_line_pkg.sv | 28 ++
 rtl/data_memory_line_line_ram.sv | 42 ++++
 rtl/data_memory_line.sv | 161 ++++++++++++++++
 tb/tb_data_memory_line.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_line_pkg.sv
// Shared constants and types for the line-granular data memory.
// Also imported by the data cache and by the bench so that the line width,
// default latency and default depth have a single definition.
package mem_pkg;

  // Line geometry
  localparam int LINE_W           = 256;
  localparam int LINE_OFFSET_BITS = 5;
  localparam int ADDR_W           = 32;

  // Default timing and capacity
  localparam int DEF_LATENCY = 10;
  localparam int DEF_DEPTH   = 512;

  // Request sequencing states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } mem_state_t;

  // Drop the byte-within-line offset. The caller truncates the result to its
  // own index width, which discards the address bits above the array.
  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> LINE_OFFSET_BITS;
  endfunction

endpackage

// File: rtl/data_memory_line_line_ram.sv
// Single-port DEPTH x LINE_W line store with write enable and a registered
// read port. Array contents are never reset. Only the read register is reset.
module line_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LINE_W-1:0] wdata,
  output logic [LINE_W-1:0] rdata
);

  logic [LINE_W-1:0] mem_r [DEPTH];
  logic [LINE_W-1:0] rdata_r;

  // Commit a line write. The caller has already blocked writes during reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Registered read. The value is held until the next read so that writes
  // leave the output untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/data_memory_line.sv
// Fixed-latency line backing store for the data cache.
// One request is accepted in IDLE. Index, direction and write data are latched
// at acceptance. The array is touched only on the WAIT->ACK edge, so a reset
// anywhere before that edge abandons the request without side effects.
module data_memory_line
  import mem_pkg::*;
#(
  parameter int LATENCY = DEF_LATENCY,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              enable_i,
  input  logic              write_i,
  input  logic [31:0]       addr_i,
  input  logic [LINE_W-1:0] data_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  // The counter only ever holds values up to LATENCY-2.
  localparam int CNT_W = (LATENCY > 2) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mem_state_t        state_r;
  mem_state_t        state_next_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [IDX_W-1:0]  idx_r;
  logic              write_r;
  logic [LINE_W-1:0] wdata_r;
  logic              ack_r;

  logic [IDX_W-1:0]  addr_idx_s;
  logic              accept_s;
  logic              commit_s;
  logic              ram_we_s;
  logic              ram_re_s;

  // Line index. Byte offset and address bits above the array are ignored, so
  // addresses that differ only in those bits alias to the same line.
  assign addr_idx_s = IDX_W'(line_addr(addr_i));

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode. ACK always returns to IDLE, which guarantees a low
  // cycle between acknowledges.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (enable_i) begin
          state_next_s = WAIT;
        end else begin
          state_next_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == '0) begin
          state_next_s = ACK;
        end else begin
          state_next_s = WAIT;
        end
      end
      ACK: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Per-state control strobes: accept in IDLE, commit on the final WAIT cycle
  always_comb begin
    accept_s = 1'b0;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        accept_s = enable_i;
      end
      WAIT: begin
        commit_s = (cnt_r == '0);
      end
      ACK: begin
        accept_s = 1'b0;
      end
      default: begin
        accept_s = 1'b0;
      end
    endcase
  end

  // A reset that coincides with the commit edge wins, and the array stays
  // unmodified.
  assign ram_we_s = commit_s &  write_r & ~rst_i;
  assign ram_re_s = commit_s & ~write_r & ~rst_i;

  // Latency counter, loaded at acceptance and counted down in WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_r <= '0;
    end else if (accept_s) begin
      cnt_r <= CNT_LOAD;
    end else if ((state_r == WAIT) && (cnt_r != '0)) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Request latch. Inputs are ignored after acceptance.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idx_r   <= '0;
      write_r <= 1'b0;
      wdata_r <= '0;
    end else if (accept_s) begin
      idx_r   <= addr_idx_s;
      write_r <= write_i;
      wdata_r <= data_i;
    end else begin
      idx_r   <= idx_r;
      write_r <= write_r;
      wdata_r <= wdata_r;
    end
  end

  // Acknowledge register. It rises on the commit edge, together with the
  // read data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_r <= 1'b0;
    end else begin
      ack_r <= commit_s;
    end
  end

  line_ram #(
    .DEPTH (DEPTH)
  ) u_line_ram (
    .clk   (clk_i),
    .rst   (rst_i),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .addr  (idx_r),
    .wdata (wdata_r),
    .rdata (data_o)
  );

  assign ack_o = ack_r;

endmodule

// File: tb/tb_data_memory_line.sv
// Bench for data_memory_line: directed vector table, randomized transactions
// against a line-array reference model, and hand sequences for back-to-back,
// reset-in-flight and reset-with-request cases.
module tb_data_memory_line;
  import mem_pkg::*;

  localparam int L = DEF_LATENCY;
  localparam int D = DEF_DEPTH;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic         enable_i = 1'b0;
  logic         write_i = 1'b0;
  logic [31:0]  addr_i = 32'h0;
  logic [255:0] data_i = 256'h0;
  logic         ack_o;
  logic [255:0] data_o;

  always #5 clk_i = ~clk_i;

  data_memory_line #(.LATENCY(L), .DEPTH(D)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .write_i  (write_i),
    .addr_i   (addr_i),
    .data_i   (data_i),
    .ack_o    (ack_o),
    .data_o   (data_o)
  );

  int total = 0;
  int bad = 0;

  // Reference model: the line array plus the last value read out
  logic [255:0] mem_m [D];
  logic [255:0] dout_m;

  typedef struct {
    bit           w;
    logic [31:0]  addr;
    logic [255:0] data;
    logic [255:0] exp;
  } vec_t;
  vec_t vecs [8];

  localparam logic [255:0] PAT1 = {4{64'hDEAD_BEEF_CAFE_F00D}};
  localparam logic [255:0] PAT2 = {8{32'h0123_4567}};
  localparam logic [255:0] ONES = {256{1'b1}};

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int idx_of(input logic [31:0] a);
    return int'((a >> 5) % D);
  endfunction

  // Issue one request and scramble the inputs right after acceptance.
  // lat is the number of cycles from acceptance to the first ack cycle.
  task automatic run_txn(input bit w, input logic [31:0] a, input logic [255:0] d,
                         output int lat, output logic [255:0] rd, output logic after);
    bit seen;
    @(negedge clk_i);
    enable_i = 1'b1; write_i = w; addr_i = a; data_i = d;
    @(posedge clk_i);
    #1;
    enable_i = 1'b0;
    write_i  = 1'($urandom_range(0, 1));
    addr_i   = $urandom;
    data_i   = rand_line();
    seen = 1'b0;
    lat  = 0;
    rd   = '0;
    while (!seen && lat < L + 5) begin
      @(negedge clk_i);
      lat++;
      if (ack_o) begin
        seen = 1'b1;
        rd = data_o;
      end
    end
    @(negedge clk_i);
    after = ack_o;
  endtask

  // Run one transaction, update the model and check latency, data and pulse width
  task automatic do_txn(input string nm, input bit w, input logic [31:0] a,
                        input logic [255:0] d, input logic [255:0] exp);
    int lat;
    logic [255:0] rd;
    logic after;
    run_txn(w, a, d, lat, rd, after);
    if (w) mem_m[idx_of(a)] = d;
    else   dout_m = mem_m[idx_of(a)];
    chk({nm, "_lat"}, 256'(lat), 256'(L));
    chk({nm, "_data"}, rd, exp);
    chk({nm, "_pulse"}, 256'(after), 256'(0));
  endtask

  task automatic count_acks(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk_i);
      if (ack_o) c++;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c1, c2, n_ack, first, second;
    logic [255:0] d, prior, rd;
    logic [31:0] a;
    bit w;

    vecs[0] = '{1'b0, 32'h0000_0060, 256'h0, 256'h0};
    vecs[1] = '{1'b1, 32'h0000_0400, PAT1,   256'h0};
    vecs[2] = '{1'b0, 32'h0000_041C, 256'h0, PAT1};
    vecs[3] = '{1'b1, 32'h0000_4020, PAT2,   PAT1};
    vecs[4] = '{1'b0, 32'h0000_0020, 256'h0, PAT2};
    vecs[5] = '{1'b1, 32'h0000_3FE0, ONES,   PAT2};
    vecs[6] = '{1'b0, 32'hFFFF_FFE0, 256'h0, ONES};
    vecs[7] = '{1'b0, 32'h0000_07E0, 256'h0, 256'h0};

    // Reset state
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    chk("reset_ack", 256'(ack_o), 256'(0));
    chk("reset_data", data_o, 256'h0);
    rst_i = 1'b0;
    dout_m = '0;

    // Bring every line to a known zero value through the normal write path
    for (int i = 0; i < D; i++) do_txn("zero", 1'b1, 32'(i) << 5, 256'h0, 256'h0);

    // Directed vector table
    for (int i = 0; i < 8; i++) do_txn($sformatf("vec%0d", i), vecs[i].w, vecs[i].addr, vecs[i].data, vecs[i].exp);

    // Randomized transactions on a small set of lines with random junk in the ignored bits
    for (int i = 0; i < 60; i++) begin
      w = 1'($urandom_range(0, 1));
      a = ($urandom & 32'hFFFF_C01F) | (32'($urandom_range(0, 15)) << 5);
      d = rand_line();
      do_txn("rand", w, a, d, w ? dout_m : mem_m[idx_of(a)]);
      repeat ($urandom_range(0, 3)) @(negedge clk_i);
    end

    // Back-to-back write-back and refill with enable held through ACK
    d = rand_line();
    prior = mem_m[idx_of(32'h0000_0800)];
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0C00; data_i = d;
    n_ack = 0; first = 0; second = 0; rd = '0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk_i);
      if (ack_o) begin
        n_ack++;
        if (n_ack == 1) begin
          first = k;
          write_i = 1'b0; addr_i = 32'h0000_0800; data_i = rand_line();
        end else begin
          second = k;
          rd = data_o;
          enable_i = 1'b0;
        end
      end
    end
    enable_i = 1'b0;
    mem_m[idx_of(32'h0000_0C00)] = d;
    dout_m = prior;
    chk("b2b_count", 256'(n_ack), 256'(2));
    chk("b2b_first", 256'(first), 256'(L));
    chk("b2b_second", 256'(second), 256'(2 * L + 1));
    chk("b2b_data", rd, prior);
    do_txn("b2b_wb_rd", 1'b0, 32'h0000_0C00, 256'h0, d);

    // Reset five cycles into a write of all ones to line 7
    prior = mem_m[7];
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_00E0; data_i = ONES;
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    count_acks(4, c1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstw_ack", 256'(ack_o), 256'(0));
    chk("rstw_data", data_o, 256'h0);
    rst_i = 1'b0;
    dout_m = '0;
    count_acks(15, c2);
    chk("rstw_noack", 256'(c1 + c2), 256'(0));
    do_txn("rstw_rd7", 1'b0, 32'h0000_00E0, 256'h0, prior);

    // Reset exactly on the commit edge of a write to line 8
    prior = mem_m[8];
    @(negedge clk_i);
    enable_i = 1'b1; write_i = 1'b1; addr_i = 32'h0000_0100; data_i = rand_line();
    @(posedge clk_i);
    #1 enable_i = 1'b0;
    count_acks(8, c1);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rstc_ack", 256'(ack_o), 256'(0));
    rst_i = 1'b0;
    dout_m = '0;
    count_acks(15, c2);
    chk("rstc_noack", 256'(c1 + c2), 256'(0));
    do_txn("rstc_rd8", 1'b0, 32'h0000_0100, 256'h0, prior);

    // Request presented together with reset in IDLE is not accepted
    @(negedge clk_i);
    rst_i = 1'b1; enable_i = 1'b1; write_i = 1'b0; addr_i = 32'h0000_0060;
    @(negedge clk_i);
    rst_i = 1'b0; enable_i = 1'b0;
    dout_m = '0;
    count_acks(15, c1);
    chk("rst_en_noack", 256'(c1), 256'(0));
    chk("rst_en_data", data_o, 256'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
